// File: rtl/flick_conditioner.sv
// flick_conditioner: push-button conditioner for the flasher.
// Synchronizes a bouncing button, debounces press and release, emits a
// single-cycle FLICK per accepted press and counts rejected bounces.
module flick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BTN_RAW,
    output logic                FLICK,
    output logic                PRESSED,
    output logic [GLITCH_W-1:0] GLITCH_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [15:0]         CNT_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic [1:0]          sync_reg;
    logic [1:0]          sync_vld_reg;
    logic                btn_s;
    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic                flick_reg, flick_next;
    logic                pressed_reg, pressed_next;
    logic [GLITCH_W-1:0] glitch_reg, glitch_next;
    logic                glitch_inc;
    logic                armed_reg, armed_next;

    assign btn_s = sync_reg[1];

    // Two-flop synchronizer. sync_vld_reg tracks when btn_s holds a real
    // post-reset sample rather than the cleared reset value, so a button
    // held through reset is never mistaken for a release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg     <= '0;
            sync_vld_reg <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], BTN_RAW};
            sync_vld_reg <= {sync_vld_reg[0], 1'b1};
        end
    end

    // State, counter and output registers; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            flick_reg   <= 1'b0;
            pressed_reg <= 1'b0;
            glitch_reg  <= '0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            flick_reg   <= flick_next;
            pressed_reg <= pressed_next;
            glitch_reg  <= glitch_next;
            armed_reg   <= armed_next;
        end
    end

    // Debounce FSM: next state, counter, pulse and glitch bookkeeping.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        flick_next = 1'b0;
        glitch_inc = 1'b0;
        armed_next = armed_reg | (sync_vld_reg[1] & ~btn_s);

        case (state_reg)
            IDLE: begin
                if (btn_s && armed_reg) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = 16'd1;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    flick_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = 16'd1;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        pressed_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
        glitch_next  = (glitch_inc && (glitch_reg != GLITCH_MAX))
                     ? glitch_reg + GLITCH_ONE : glitch_reg;
    end

    assign FLICK      = flick_reg;
    assign PRESSED    = pressed_reg;
    assign GLITCH_CNT = glitch_reg;

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed bench for flick_conditioner (DEBOUNCE_CYCLES=4, GLITCH_W=8).
// Vector i drives RST/BTN_RAW ahead of edge i; outputs are checked 1 ns after it.
module tb_flick_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       flick;
    logic       pressed;
    logic [7:0] glitch_cnt;

    int checks      = 0;
    int failures    = 0;
    int flick_total = 0;

    typedef struct {
        logic       rst;
        logic       btn;
        logic       flick;
        logic       pressed;
        logic [7:0] glitch;
    } vec_t;

    vec_t tbl[19];

    flick_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .GLITCH_W       (8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .BTN_RAW   (btn),
        .FLICK     (flick),
        .PRESSED   (pressed),
        .GLITCH_CNT(glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: drive inputs, take the edge, then sample outputs.
    task automatic cyc(input logic r, input logic b);
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
        if (flick === 1'b1) flick_total++;
    endtask

    task automatic cycn(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) cyc(r, b);
    endtask

    int f0;

    initial begin
        // Clean press at edge 4 then release at edge 12.
        for (int i = 0; i < 19; i++) begin
            tbl[i].rst     = 1'b0;
            tbl[i].btn     = (i >= 4 && i <= 11);
            tbl[i].flick   = (i == 9);
            tbl[i].pressed = (i >= 9 && i <= 16);
            tbl[i].glitch  = 8'd0;
        end
        tbl[0].rst = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].rst, tbl[i].btn);
            chk($sformatf("clean[%0d].flick", i),   int'(flick),      int'(tbl[i].flick));
            chk($sformatf("clean[%0d].pressed", i), int'(pressed),    int'(tbl[i].pressed));
            chk($sformatf("clean[%0d].glitch", i),  int'(glitch_cnt), int'(tbl[i].glitch));
        end

        // Bounce: 1,1,0,1,1,0 then stable high.
        f0 = flick_total;
        cycn(0, 1, 2); cyc(0, 0); cycn(0, 1, 2); cyc(0, 0); cycn(0, 1, 12);
        chk("bounce.flicks",  flick_total - f0, 1);
        chk("bounce.glitch",  int'(glitch_cnt), 2);
        chk("bounce.pressed", int'(pressed), 1);

        // Release glitch: two low cycles while held.
        f0 = flick_total;
        cycn(0, 0, 2);
        cycn(0, 1, 10);
        chk("relglitch.flicks",  flick_total - f0, 0);
        chk("relglitch.glitch",  int'(glitch_cnt), 3);
        chk("relglitch.pressed", int'(pressed), 1);
        cycn(0, 0, 8);
        chk("release.pressed", int'(pressed), 0);

        // Held through reset.
        f0 = flick_total;
        cyc(1, 1);
        chk("heldrst.glitch", int'(glitch_cnt), 0);
        cycn(0, 1, 30);
        chk("heldrst.flicks",  flick_total - f0, 0);
        chk("heldrst.pressed", int'(pressed), 0);
        cycn(0, 0, 6);
        chk("heldrst.rel_pressed", int'(pressed), 0);
        cycn(0, 1, 12);
        chk("heldrst.repress_flicks", flick_total - f0, 1);
        chk("heldrst.repress_pressed", int'(pressed), 1);

        // Saturation: 300 single-cycle pulses.
        cyc(1, 0);
        cycn(0, 0, 4);
        f0 = flick_total;
        for (int p = 0; p < 300; p++) begin
            cyc(0, 1);
            cycn(0, 0, 3);
        end
        cycn(0, 0, 3);
        chk("sat.glitch", int'(glitch_cnt), 255);
        chk("sat.flicks", flick_total - f0, 0);

        // Reset while PRESS_WAIT has cnt=2.
        cycn(0, 1, 4);
        chk("midpw.pre_pressed", int'(pressed), 0);
        cyc(1, 1);
        chk("midpw.flick",   int'(flick), 0);
        chk("midpw.pressed", int'(pressed), 0);
        chk("midpw.glitch",  int'(glitch_cnt), 0);
        f0 = flick_total;
        cycn(0, 1, 10);
        chk("midpw.held_flicks", flick_total - f0, 0);

        // Reset on the very edge that would raise FLICK.
        cycn(0, 0, 6);
        f0 = flick_total;
        cycn(0, 1, 5);
        cyc(1, 1);
        chk("rstprio.flick", int'(flick), 0);
        chk("rstprio.pressed", int'(pressed), 0);
        cycn(0, 1, 8);
        chk("rstprio.flicks", flick_total - f0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
